gf_serial_host: RTL

- Host-side end of the bit-serial operand/result link used by the GF arithmetic top level.
- Accepts one parallel command: operands, reduction polynomial, polynomial grade, reduction input and mode bits.
- Serializes the command onto the top's serial input pins and pulses the top's enable.
- Deserializes the serial result pins back into parallel words and presents them with a valid/ready handshake.

---
 rtl/gf_serial_host_pkg.sv | 23 ++
 rtl/gf_host_lane_shifter.sv | 31 +++
 rtl/gf_serial_host.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/gf_serial_host_pkg.sv
// rtl/gf_serial_host_pkg.sv - shared types and constants for the GF serial host.
package gf_serial_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    COMPUTE,
    SETTLE,
    RECV,
    RESP
  } state_t;

  // Bit positions inside the 4-bit mode word {carry, sum, exp, red}.
  localparam int MODE_RED   = 0;
  localparam int MODE_EXP   = 1;
  localparam int MODE_SUM   = 2;
  localparam int MODE_CARRY = 3;

  function automatic int counter_width(input int data_width);
    return $clog2(2 * data_width);
  endfunction

endpackage

// File: rtl/gf_host_lane_shifter.sv
// rtl/gf_host_lane_shifter.sv - one serial lane: parallel load, MSB shift-out, LSB shift-in.
module gf_host_lane_shifter #(
  parameter int LANE_W  = 64,
  parameter int FIELD_W = 32,
  parameter int OUT_W   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic [FIELD_W-1:0] data,
  input  logic               bit_in,
  output logic [OUT_W-1:0]   q
);

  logic [LANE_W-1:0] sh;

  // Load is right-aligned and zero-extended, so short fields lead with zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh <= '0;
    end else if (load) begin
      sh <= LANE_W'(data);
    end else if (shift) begin
      sh <= {sh[LANE_W-2:0], bit_in};
    end
  end

  assign q = sh[LANE_W-1 -: OUT_W];

endmodule

// File: rtl/gf_serial_host.sv
// rtl/gf_serial_host.sv - host side of the GF bit-serial link; GF_SERIAL_HOST_PARITY_EN adds rsp_parity.
module gf_serial_host
  import gf_serial_host_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int COMPUTE_CYCLES = 2,
  parameter int LOAD_CYCLES    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [DATA_WIDTH-1:0]         cmd_a,
  input  logic [DATA_WIDTH-1:0]         cmd_b,
  input  logic [$clog2(DATA_WIDTH):0]   cmd_grade,
  input  logic [DATA_WIDTH:0]           cmd_poly,
  input  logic [2*DATA_WIDTH-1:0]       cmd_reduc,
  input  logic [3:0]                    cmd_mode,
  output logic                          ser_a,
  output logic                          ser_b,
  output logic                          ser_grade,
  output logic                          ser_poly,
  output logic                          ser_reduc,
  output logic [3:0]                    dut_mode,
  output logic                          dut_enable,
  input  logic                          ser_sum,
  input  logic                          ser_mult,
  input  logic                          ser_poly_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_sum,
  output logic [2*DATA_WIDTH-1:0]       rsp_mult,
  output logic [DATA_WIDTH-1:0]         rsp_poly
`ifdef GF_SERIAL_HOST_PARITY_EN
  ,
  output logic [2:0]                    rsp_parity
`endif
);

  localparam int W  = DATA_WIDTH;
  localparam int L  = 2 * DATA_WIDTH;
  localparam int GW = $clog2(DATA_WIDTH) + 1;
  // Counter also times COMPUTE/SETTLE, which may need up to 15.
  localparam int CW = (counter_width(W) > 4) ? counter_width(W) : 4;

  localparam logic [CW-1:0] LAST_BIT     = CW'(L - 1);
  localparam logic [CW-1:0] LAST_COMPUTE = CW'(COMPUTE_CYCLES - 1);
  localparam logic [CW-1:0] LAST_LOAD    = CW'((LOAD_CYCLES > 0) ? LOAD_CYCLES - 1 : 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          sending;
  logic          receiving;
  logic [4:0]    tx_bit;

  assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
  assign sending   = (state == SEND);
  assign receiving = (state == RECV);

  gf_host_lane_shifter #(.LANE_W(L), .FIELD_W(W), .OUT_W(1)) u_tx_a (
    .clk(clk), .reset(reset), .load(accept), .shift(sending),
    .data(cmd_a), .bit_in(1'b0), .q(tx_bit[0])
  );

  gf_host_lane_shifter #(.LANE_W(L), .FIELD_W(W), .OUT_W(1)) u_tx_b (
    .clk(clk), .reset(reset), .load(accept), .shift(sending),
    .data(cmd_b), .bit_in(1'b0), .q(tx_bit[1])
  );

  gf_host_lane_shifter #(.LANE_W(L), .FIELD_W(GW), .OUT_W(1)) u_tx_grade (
    .clk(clk), .reset(reset), .load(accept), .shift(sending),
    .data(cmd_grade), .bit_in(1'b0), .q(tx_bit[2])
  );

  gf_host_lane_shifter #(.LANE_W(L), .FIELD_W(W + 1), .OUT_W(1)) u_tx_poly (
    .clk(clk), .reset(reset), .load(accept), .shift(sending),
    .data(cmd_poly), .bit_in(1'b0), .q(tx_bit[3])
  );

  gf_host_lane_shifter #(.LANE_W(L), .FIELD_W(L), .OUT_W(1)) u_tx_reduc (
    .clk(clk), .reset(reset), .load(accept), .shift(sending),
    .data(cmd_reduc), .bit_in(1'b0), .q(tx_bit[4])
  );

  assign ser_a     = sending & tx_bit[0];
  assign ser_b     = sending & tx_bit[1];
  assign ser_grade = sending & tx_bit[2];
  assign ser_poly  = sending & tx_bit[3];
  assign ser_reduc = sending & tx_bit[4];

  // Receive lanes drive rsp_* directly: they only move in RECV, so values hold through RESP and IDLE.
  // Sum and poly keep just the last W bits of their 2W-bit stream, which is all that is presented.
  gf_host_lane_shifter #(.LANE_W(W), .FIELD_W(1), .OUT_W(W)) u_rx_sum (
    .clk(clk), .reset(reset), .load(1'b0), .shift(receiving),
    .data(1'b0), .bit_in(ser_sum), .q(rsp_sum)
  );

  gf_host_lane_shifter #(.LANE_W(L), .FIELD_W(1), .OUT_W(L)) u_rx_mult (
    .clk(clk), .reset(reset), .load(1'b0), .shift(receiving),
    .data(1'b0), .bit_in(ser_mult), .q(rsp_mult)
  );

  gf_host_lane_shifter #(.LANE_W(W), .FIELD_W(1), .OUT_W(W)) u_rx_poly (
    .clk(clk), .reset(reset), .load(1'b0), .shift(receiving),
    .data(1'b0), .bit_in(ser_poly_out), .q(rsp_poly)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cmd_ready  <= 1'b0;
      dut_mode   <= '0;
      dut_enable <= 1'b0;
      rsp_valid  <= 1'b0;
`ifdef GF_SERIAL_HOST_PARITY_EN
      rsp_parity <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            dut_mode  <= cmd_mode;
            cnt       <= '0;
            state     <= SEND;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SEND: begin
          if (cnt == LAST_BIT) begin
            cnt        <= '0;
            dut_enable <= 1'b1;
            state      <= COMPUTE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COMPUTE: begin
          if (cnt == LAST_COMPUTE) begin
            cnt        <= '0;
            dut_enable <= 1'b0;
            state      <= (LOAD_CYCLES == 0) ? RECV : SETTLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == LAST_LOAD) begin
            cnt   <= '0;
            state <= RECV;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RECV: begin
          if (cnt == LAST_BIT) begin
            cnt       <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef GF_SERIAL_HOST_PARITY_EN
            // Parity of the words as they will stand after this final shift.
            rsp_parity <= {^{rsp_poly[W-2:0], ser_poly_out},
                           ^{rsp_mult[L-2:0], ser_mult},
                           ^{rsp_sum[W-2:0], ser_sum}};
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
